// File: rtl/jtag_host.sv
// JTAG host: walks the target TAP through one IR scan and one DR scan
// per command, returning the bits captured from tdo during the DR scan.
module jtag_host #(
    parameter int TCK_HALF = 2,
    parameter int IR_LEN   = 3,
    parameter int DR_LEN   = 8
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_LEN-1:0] cmd_op,
    input  logic [DR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_LEN-1:0] rsp_data,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    input  logic              jtag_tdo
);

    localparam int MAXL = (IR_LEN > DR_LEN) ?
        ((IR_LEN > 6) ? IR_LEN : 6) : ((DR_LEN > 6) ? DR_LEN : 6);
    localparam int CW = $clog2(MAXL);

    typedef enum logic [3:0] {
        INIT, IDLE, SEL_DR, SEL_IR, CAP_IR, SH_IR,
        EX1_IR, UPD_IR, CAP_DR, SH_DR, EX1_DR, UPD_DR
    } tap_e;

    tap_e              state;
    tap_e              state_nx;
    logic [7:0]        div;
    logic              run;
    logic              in_cmd;
    logic              ir_done;
    logic [CW-1:0]     cnt;
    logic [IR_LEN-1:0] op_sh;
    logic [DR_LEN-1:0] data_sh;
    logic [DR_LEN-1:0] cap;
    logic              tick;
    logic              rise;
    logic              fall;
    logic              accept;
    logic              tms_nx;
    logic              tdi_nx;

    assign tick   = run && (div == 8'(TCK_HALF - 1));
    assign rise   = tick && !jtag_tck;
    assign fall   = tick && jtag_tck;
    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) state <= INIT;
        else         state <= state_nx;
    end

    // TAP follows the tms value presented at each tck rise
    always_comb begin
        state_nx = state;
        if (rise) begin
            unique case (state)
                INIT:          if (cnt == CW'(5)) state_nx = IDLE;
                IDLE:          if (jtag_tms) state_nx = SEL_DR;
                SEL_DR:        state_nx = jtag_tms ? SEL_IR : CAP_DR;
                SEL_IR:        state_nx = jtag_tms ? INIT : CAP_IR;
                CAP_IR, SH_IR: state_nx = jtag_tms ? EX1_IR : SH_IR;
                EX1_IR:        state_nx = jtag_tms ? UPD_IR : SH_IR;
                UPD_IR:        state_nx = jtag_tms ? SEL_DR : IDLE;
                CAP_DR, SH_DR: state_nx = jtag_tms ? EX1_DR : SH_DR;
                EX1_DR:        state_nx = jtag_tms ? UPD_DR : SH_DR;
                UPD_DR:        state_nx = jtag_tms ? SEL_DR : IDLE;
                default:       state_nx = INIT;
            endcase
        end
    end

    // tms/tdi for the tck cycle whose rise happens in the current state
    always_comb begin
        tms_nx = 1'b0;
        tdi_nx = 1'b0;
        unique case (state)
            INIT:                        tms_nx = cnt < CW'(5);
            IDLE, EX1_IR, UPD_IR, EX1_DR: tms_nx = 1'b1;
            SEL_DR:                      tms_nx = !ir_done;
            SH_IR: begin
                tms_nx = cnt == CW'(IR_LEN - 1);
                tdi_nx = op_sh[0];
            end
            SH_DR: begin
                tms_nx = cnt == CW'(DR_LEN - 1);
                tdi_nx = data_sh[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            div       <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            run       <= 1'b1;
            in_cmd    <= 1'b0;
            ir_done   <= 1'b0;
            cnt       <= '0;
            op_sh     <= '0;
            data_sh   <= '0;
            cap       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                cmd_ready <= 1'b0;
                run       <= 1'b1;
                in_cmd    <= 1'b1;
                ir_done   <= 1'b0;
                div       <= '0;
                op_sh     <= cmd_op;
                data_sh   <= cmd_data;
                jtag_tms  <= tms_nx;
                jtag_tdi  <= 1'b0;
            end else if (run) begin
                div <= tick ? 8'd0 : div + 8'd1;
                if (rise) begin
                    jtag_tck <= 1'b1;
                    unique case (state)
                        INIT:
                            cnt <= (cnt == CW'(5)) ? '0 : cnt + CW'(1);
                        SH_IR, SH_DR:
                            cnt <= jtag_tms ? '0 : cnt + CW'(1);
                        default:
                            cnt <= '0;
                    endcase
                    if (state == UPD_IR) ir_done <= 1'b1;
                    if (state == SH_IR) op_sh <= op_sh >> 1;
                    if (state == SH_DR) begin
                        data_sh <= data_sh >> 1;
                        cap     <= {jtag_tdo, cap[DR_LEN-1:1]};
                    end
                end
                if (fall) begin
                    jtag_tck <= 1'b0;
                    if (state == IDLE) begin
                        run       <= 1'b0;
                        cmd_ready <= 1'b1;
                        in_cmd    <= 1'b0;
                        rsp_valid <= in_cmd;
                        jtag_tdi  <= 1'b0;
                        if (in_cmd) rsp_data <= cap;
                    end else begin
                        jtag_tms <= tms_nx;
                        jtag_tdi <= tdi_nx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: clk-accurate timing model of the scan sequence
// plus a simple target that feeds tdo and records the shifted tdi bits.
module tb_jtag_host;

    localparam int H  = 2;
    localparam int IR = 3;
    localparam int DR = 8;
    localparam int NC = IR + DR + 10;

    logic          clk = 1'b0;
    logic          aclr_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IR-1:0] cmd_op;
    logic [DR-1:0] cmd_data;
    logic          rsp_valid;
    logic [DR-1:0] rsp_data;
    logic          jtag_tck;
    logic          jtag_tms;
    logic          jtag_tdi;
    logic          jtag_tdo;

    jtag_host #(.TCK_HALF(H), .IR_LEN(IR), .DR_LEN(DR)) dut (
        .clk(clk), .aclr_n(aclr_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
        .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: mode 0 = init sequence, 1 = command; m = clk edges since start
    int            mode = 0;
    int            m = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            n_acc = 0;
    int            n_rsp = 0;
    int            epoch = 0;
    int            seen = 0;
    int            rc = 0;
    int            rc_nx;
    int            last_lat = 0;
    logic [IR-1:0] op_q = '0;
    logic [DR-1:0] data_q = '0;
    logic [DR-1:0] cap_q = '0;
    logic [DR-1:0] tb_cap = '0;
    logic [DR-1:0] exp_rsp = '0;
    logic [DR-1:0] upd = '0;
    logic [DR-1:0] last_upd = '0;
    logic [IR-1:0] ir_tdi = '0;
    logic [5:0]    init_tms = '0;
    logic [DR-1:0] tdo_sh;
    logic          noise = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, want, $time);
        end
    endtask

    task automatic fail_to(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    function automatic int tot(input int md);
        return 2 * H * ((md == 1) ? NC : 6);
    endfunction

    function automatic logic e_tck(input int md, input int mm);
        return (mm < tot(md)) && ((mm / H) % 2 == 1);
    endfunction

    function automatic logic e_tms(input int md, input int mm);
        int c;
        if (mm >= tot(md)) return 1'b0;
        c = mm / (2 * H);
        if (md == 0) return c < 5;
        if (c < 4) return c < 2;
        c -= 4;
        if (c < IR) return c == IR - 1;
        c -= IR;
        if (c < 4) return c < 2;
        c -= 4;
        if (c < DR) return c == DR - 1;
        c -= DR;
        return c == 0;
    endfunction

    function automatic logic e_tdi(input int md, input int mm);
        int            c;
        logic [IR-1:0] o;
        logic [DR-1:0] d;
        if (md == 0 || mm >= tot(md)) return 1'b0;
        c = mm / (2 * H);
        if (c >= 4 && c < 4 + IR) begin
            o = op_q >> (c - 4);
            return o[0];
        end
        if (c >= IR + 8 && c < IR + 8 + DR) begin
            d = data_q >> (c - IR - 8);
            return d[0];
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!aclr_n) begin
            mode  <= 0;
            m     <= 0;
            epoch <= epoch + 1;
        end else if (cmd_valid && m >= tot(mode)) begin
            mode    <= 1;
            m       <= 0;
            epoch   <= epoch + 1;
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            cap_q   <= tb_cap;
            acc_cyc <= cyc + 1;
            n_acc   <= n_acc + 1;
        end else begin
            m <= m + 1;
        end
    end

    // target side: count tck rises, log tms/tdi, present captured DR bits
    assign rc_nx  = (seen != epoch) ? 1 : rc + 1;
    assign tdo_sh = cap_q >> (rc - IR - 8);
    assign jtag_tdo = (mode == 1 && rc >= IR + 8 && rc < IR + 8 + DR) ?
                      tdo_sh[0] : noise;

    always @(posedge jtag_tck) begin
        rc   <= rc_nx;
        seen <= epoch;
        if (mode == 0) init_tms <= {jtag_tms, init_tms[5:1]};
        if (mode == 1 && rc_nx >= 5 && rc_nx < 5 + IR)
            ir_tdi <= {jtag_tdi, ir_tdi[IR-1:1]};
        if (mode == 1 && rc_nx >= IR + 9 && rc_nx < IR + 9 + DR)
            upd <= {jtag_tdi, upd[DR-1:1]};
    end

    always @(negedge clk) begin
        noise <= 1'($urandom);
        if (!aclr_n) begin
            chk("rst_tck", 32'(jtag_tck), 32'(0));
            chk("rst_tms", 32'(jtag_tms), 32'(1));
            chk("rst_tdi", 32'(jtag_tdi), 32'(0));
            chk("rst_ready", 32'(cmd_ready), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_rsp_data", 32'(rsp_data), 32'(0));
            exp_rsp <= '0;
        end else begin
            chk("tck", 32'(jtag_tck), 32'(e_tck(mode, m)));
            chk("tms", 32'(jtag_tms), 32'(e_tms(mode, m)));
            chk("tdi", 32'(jtag_tdi), 32'(e_tdi(mode, m)));
            chk("cmd_ready", 32'(cmd_ready), 32'(m >= tot(mode)));
            chk("rsp_valid", 32'(rsp_valid),
                32'(mode == 1 && m == tot(mode)));
            chk("rsp_data", 32'(rsp_data),
                32'((mode == 1 && m == tot(mode)) ? cap_q : exp_rsp));
            if (mode == 1 && m == tot(mode)) begin
                exp_rsp  <= cap_q;
                last_upd <= upd;
                last_lat <= cyc - acc_cyc;
                chk("target_update_dr", 32'(upd), 32'(data_q));
            end
            if (m == tot(mode))
                chk("tck_count", rc, (mode == 1) ? NC : 6);
            if (rsp_valid) n_rsp <= n_rsp + 1;
        end
    end

    task automatic wait_ready();
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (cmd_ready) got = 1;
        end
        if (!got) fail_to("wait_ready");
    endtask

    task automatic issue(input logic [IR-1:0] op, input logic [DR-1:0] d,
                         input logic [DR-1:0] cp);
        bit got = 0;
        cmd_op    = op;
        cmd_data  = d;
        tb_cap    = cp;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            if (cmd_ready) got = 1;
        end
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 8'($urandom);
        if (!got) fail_to("accept");
    endtask

    task automatic wait_rsp();
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        #1;
        if (!got) fail_to("wait_rsp");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DR-1:0] cp;
        int            r0;
        aclr_n    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        repeat (3) @(posedge clk);
        #1 aclr_n = 1'b1;
        wait_ready();
        chk("init_tms_seq", 32'(init_tms), 32'(6'b011111));
        chk("init_no_rsp", n_rsp, 0);

        issue(3'b001, 8'hA5, 8'($urandom));
        wait_rsp();
        chk("write_ir_tdi", 32'(ir_tdi), 32'(3'b001));
        chk("write_update_dr", 32'(last_upd), 32'(8'hA5));

        issue(3'b000, 8'($urandom), 8'h3C);
        wait_rsp();
        chk("read_rsp", 32'(rsp_data), 32'(8'h3C));
        chk("read_latency", last_lat, 84);

        issue(3'b010, 8'($urandom), 8'h06);
        wait_rsp();
        chk("status_rsp", 32'(rsp_data), 32'(8'h06));

        for (int n = 0; n < 10; n++) begin
            cp = 8'($urandom);
            issue(3'($urandom), 8'($urandom), cp);
            wait_rsp();
            chk("rand_rsp", 32'(rsp_data), 32'(cp));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // cmd_valid held high across several commands
        cmd_op    = 3'($urandom);
        cmd_data  = 8'($urandom);
        tb_cap    = 8'($urandom);
        cmd_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bit got = 0;
            for (int i = 0; i < 400 && !got; i++) begin
                @(posedge clk);
                if (cmd_ready) got = 1;
            end
            if (!got) fail_to("b2b_accept");
            #1;
            cmd_op   = 3'($urandom);
            cmd_data = 8'($urandom);
            tb_cap   = 8'($urandom);
        end
        cmd_valid = 1'b0;
        wait_rsp();
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_rsp_count", n_rsp, n_acc);

        // reset pulse while the DR scan is shifting
        issue(3'b000, 8'($urandom), 8'($urandom));
        repeat (2 * H * (IR + 12) - 1) @(posedge clk);
        #1 aclr_n = 1'b0;
        r0 = n_rsp;
        repeat (3) @(posedge clk);
        #1 aclr_n = 1'b1;
        wait_ready();
        chk("abort_no_rsp", n_rsp, r0);
        chk("reinit_tms_seq", 32'(init_tms), 32'(6'b011111));
        cp = 8'($urandom);
        issue(3'b001, 8'h5A, cp);
        wait_rsp();
        chk("post_abort_rsp", 32'(rsp_data), 32'(cp));
        chk("post_abort_update_dr", 32'(last_upd), 32'(8'h5A));

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 SHALL have parameter TCK_HALF, default 2: clk cycles per tck half-period (legal range 1..255).
REQ-002 SHALL have parameter IR_LEN, default 3: instruction register length in bits.
REQ-003 SHALL have parameter DR_LEN, default 8: data register length in bits.
REQ-004 clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 aclr_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  host idle in Run-Test/Idle and able to accept a command.
REQ-008 cmd_op  input  IR_LEN  instruction to scan: 000 READ, 001 WRITE, 010 STATUS.
REQ-009 cmd_data  input  DR_LEN  value shifted out on tdi during the DR scan.
REQ-010 rsp_valid  output  1  one-clk pulse; rsp_data is valid.
REQ-011 rsp_data  output  DR_LEN  bits captured from tdo during the DR scan.
REQ-012 jtag_tck / jtag_tms / jtag_tdi  output  1 each  JTAG drive to the target TAP.
REQ-013 jtag_tdo  input  1  JTAG data from the target.

Function
REQ-014 SHALL toggle jtag_tck every TCK_HALF clk cycles while a sequence is active; tck SHALL idle low otherwise.
REQ-015 SHALL update jtag_tms and jtag_tdi only in the clk cycle that drives tck low; it SHALL sample jtag_tdo only in the clk cycle that drives tck high.
REQ-016 SHALL track the TAP with states INIT, IDLE, SEL_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, UPD_IR, CAP_DR, SH_DR, EX1_DR, UPD_DR, with one state advance per tck rising edge.
REQ-017 INIT: after reset SHALL issue 5 tck cycles with TMS=1, then 1 with TMS=0, then enter IDLE.
REQ-018 SHALL hold cmd_ready high only in IDLE with tck low. The command SHALL be accepted on the clk where cmd_valid and cmd_ready are both high; cmd_op and cmd_data SHALL be latched then.
REQ-019 Per command, the TMS sequence SHALL be 1,1,0,0 (to SH_IR), then IR_LEN shift cycles, then 1,1,0,0 (UPD_IR, SEL_DR, CAP_DR, SH_DR), then DR_LEN shift cycles, then 1,0 (UPD_DR, IDLE).
REQ-020 The IR scan SHALL shift cmd_op LSB first. The DR scan SHALL shift cmd_data LSB first. TMS SHALL be 0 on every shift cycle except the last of each scan, where TMS SHALL be 1.
REQ-021 On the k-th DR shift rising edge (k = 0..DR_LEN-1), the host SHALL store jtag_tdo into rsp_data bit k. tdo bits sampled during the IR scan SHALL be discarded.
REQ-022 A command SHALL take exactly IR_LEN+DR_LEN+10 tck cycles (21 at defaults), i.e. 2*TCK_HALF*(IR_LEN+DR_LEN+10) clk cycles from acceptance.
REQ-023 rsp_valid SHALL pulse for 1 clk in the cycle after the final tck falling edge. rsp_data SHALL hold its value until the next rsp_valid. cmd_ready SHALL rise in the same cycle as rsp_valid.
REQ-024 jtag_tdi SHALL be 0 outside shift states.
REQ-025 cmd_valid asserted while cmd_ready is low SHALL be ignored; there is no queuing.
REQ-026 Back-to-back commands SHALL each return through IDLE; no command SHALL skip the IR scan.
REQ-027 cmd_op values other than 000/001/010 SHALL still be scanned verbatim; the target treats them as bypass.

Reset
REQ-028 While aclr_n is low: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, state=INIT, divider and bit counters=0.
REQ-029 Assertion of aclr_n mid-command SHALL abort immediately with no rsp_valid. After release, the INIT sequence of REQ-017 SHALL rerun before cmd_ready rises.

Verification
REQ-030 Release aclr_n -> 6 tck with TMS 1,1,1,1,1,0, then cmd_ready=1; no rsp_valid.
REQ-031 WRITE, cmd_data=8'hA5, with a target model -> tdi IR bits 1,0,0 then DR bits 1,0,1,0,0,1,0,1; target update-DR value 8'hA5; 21 tck; rsp_valid once.
REQ-032 READ with target DR capturing 8'h3C -> rsp_data=8'h3C at rsp_valid, exactly 84 clk after acceptance (TCK_HALF=2).
REQ-033 STATUS with target capturing 8'h06 -> rsp_data=8'h06; TMS on last IR bit and last DR bit = 1, all other shift cycles = 0.
REQ-034 cmd_valid held high continuously -> commands accepted only when cmd_ready=1, each separated by an IDLE cycle; count of rsp_valid pulses equals count of accepts.
REQ-035 aclr_n pulsed low during SH_DR -> outputs at reset values immediately, no rsp_valid, INIT rerun, then the next command completes correctly.
